// File: rtl/vga_rom_scanner.sv
// 640x480@60 VGA scan generator reading a 256x240 RGB444 image RAM, shown x2 and centred.
// Define SCROLL_EN to enable the frame-latched horizontal scroll taken from scroll_x.
module vga_rom_scanner #(
   parameter int          CLK_DIV  = 4,
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter int          X_OFFSET = 64,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic        clka,
   input  logic        rsta,
   input  logic [7:0]  scroll_x,
   output logic [15:0] rom_addr,
   input  logic [11:0] rom_data,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] WIN_BEGIN = HW'(X_OFFSET);
   localparam logic [HW-1:0] WIN_END   = HW'(X_OFFSET + 512);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic [HW-1:0] hCnt_q, hCnt_d;
   logic [VW-1:0] vCnt_q, vCnt_d;
   logic [15:0]   romAddr_q, romAddr_d;
   logic          winDly_q, winDly_d;
   logic          actDly_q, actDly_d;
   logic          hsDly_q, hsDly_d;
   logic          vsDly_q, vsDly_d;
   logic [11:0]   rgb_q, rgb_d;
   logic          de_q, de_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          frameStart_q, frameStart_d;

   logic          pixTick;
   logic          hWrap;
   logic          vWrap;
   logic          win;
   logic [HW-1:0] hRel;
   logic [7:0]    xImg;
   logic [7:0]    yImg;
   logic [7:0]    scrollEff;

`ifdef SCROLL_EN
   // Scroll is sampled once per frame so a mid-frame change never tears the picture.
   logic [7:0] scrollEff_q;

   always_ff @(posedge clka) begin
      if (rsta) begin
         scrollEff_q <= 8'h00;
      end else if (frameStart_q) begin
         scrollEff_q <= scroll_x;
      end
   end

   assign scrollEff = scrollEff_q;
`else
   logic unused_scroll;
   assign unused_scroll = ^scroll_x;
   assign scrollEff     = 8'h00;
`endif

   assign pixTick = (div_q == DIV_LAST);
   assign hWrap   = (hCnt_q == H_LAST);
   assign vWrap   = (vCnt_q == V_LAST);
   assign win     = (hCnt_q >= WIN_BEGIN) && (hCnt_q < WIN_END) && (vCnt_q < V_ACT);
   assign hRel    = hCnt_q - WIN_BEGIN;
   assign xImg    = 8'(hRel >> 1) + scrollEff;
   assign yImg    = 8'(vCnt_q >> 1);

   // Stage 1 issues the RAM address; stage 2 consumes rom_data a full pixel later.
   always_comb begin
      div_d        = pixTick ? '0 : div_q + DW'(1);
      hCnt_d       = hCnt_q;
      vCnt_d       = vCnt_q;
      romAddr_d    = romAddr_q;
      winDly_d     = winDly_q;
      actDly_d     = actDly_q;
      hsDly_d      = hsDly_q;
      vsDly_d      = vsDly_q;
      rgb_d        = rgb_q;
      de_d         = de_q;
      hs_d         = hs_q;
      vs_d         = vs_q;
      frameStart_d = 1'b0;
      if (pixTick) begin
         hCnt_d = hWrap ? '0 : hCnt_q + HW'(1);
         if (hWrap) begin
            vCnt_d = vWrap ? '0 : vCnt_q + VW'(1);
         end
         if (win) begin
            romAddr_d = {yImg, xImg};
         end
         winDly_d     = win;
         actDly_d     = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
         hsDly_d      = !((hCnt_q >= HS_BEGIN) && (hCnt_q < HS_END));
         vsDly_d      = !((vCnt_q >= VS_BEGIN) && (vCnt_q < VS_END));
         rgb_d        = winDly_q ? rom_data : (actDly_q ? BG_COLOR : 12'h000);
         de_d         = actDly_q;
         hs_d         = hsDly_q;
         vs_d         = vsDly_q;
         frameStart_d = hWrap && vWrap;
      end
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         div_q        <= '0;
         hCnt_q       <= '0;
         vCnt_q       <= '0;
         romAddr_q    <= 16'h0000;
         winDly_q     <= 1'b0;
         actDly_q     <= 1'b0;
         hsDly_q      <= 1'b1;
         vsDly_q      <= 1'b1;
         rgb_q        <= 12'h000;
         de_q         <= 1'b0;
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
         frameStart_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         hCnt_q       <= hCnt_d;
         vCnt_q       <= vCnt_d;
         romAddr_q    <= romAddr_d;
         winDly_q     <= winDly_d;
         actDly_q     <= actDly_d;
         hsDly_q      <= hsDly_d;
         vsDly_q      <= vsDly_d;
         rgb_q        <= rgb_d;
         de_q         <= de_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         frameStart_q <= frameStart_d;
      end
   end

   assign rom_addr    = romAddr_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_de      = de_q;
   assign frame_start = frameStart_q;

endmodule

// File: tb/tb_vga_rom_scanner.sv
// Scoreboard bench for vga_rom_scanner: a pixel-index reference model predicts the pin
// state after every clka edge; a monitor compares it on the falling edge.
module tb_vga_rom_scanner;

   // Vertical timing is shortened so several whole frames fit in a short run.
   localparam int          CLK_DIV  = 4;
   localparam int          H_ACTIVE = 640;
   localparam int          H_FP     = 16;
   localparam int          H_SYNC   = 96;
   localparam int          H_BP     = 48;
   localparam int          V_ACTIVE = 4;
   localparam int          V_FP     = 1;
   localparam int          V_SYNC   = 2;
   localparam int          V_BP     = 1;
   localparam int          X_OFFSET = 64;
   localparam logic [11:0] BG_COLOR = 12'hA5C;
   localparam int          H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int          V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int          FRAME    = H_TOT * V_TOT;
   localparam int          MAX_FAIL = 50;

   typedef struct {
      logic [15:0] addr;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      logic        de;
      logic        fs;
      int          edgeNo;
   } pinState_t;

   logic        clka = 1'b0;
   logic        rsta;
   logic [7:0]  scroll_x;
   logic [15:0] rom_addr;
   logic [11:0] rom_data = 12'h000;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_de;
   logic        frame_start;

   pinState_t   expQ[$];
   pinState_t   cur;
   int          testsRun  = 0;
   int          failCount = 0;
   int          kEdge     = 0;
   int          totalEdge = 0;
   logic [7:0]  mAddrScroll;
   logic [15:0] mAddr;
   logic [7:0]  scrollVal;
   logic [11:0] ramSalt;

   vga_rom_scanner #(
      .CLK_DIV (CLK_DIV),
      .H_ACTIVE(H_ACTIVE),
      .H_FP    (H_FP),
      .H_SYNC  (H_SYNC),
      .H_BP    (H_BP),
      .V_ACTIVE(V_ACTIVE),
      .V_FP    (V_FP),
      .V_SYNC  (V_SYNC),
      .V_BP    (V_BP),
      .X_OFFSET(X_OFFSET),
      .BG_COLOR(BG_COLOR)
   ) dut (
      .clka       (clka),
      .rsta       (rsta),
      .scroll_x   (scroll_x),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
      .vga_hs     (vga_hs),
      .vga_vs     (vga_vs),
      .vga_de     (vga_de),
      .frame_start(frame_start)
   );

   always #5 clka = ~clka;

   function automatic logic [11:0] ramWord(input logic [15:0] a);
      return a[11:0] ^ ramSalt;
   endfunction

   // Synchronous-read RAM: data follows the address by one clka.
   always @(posedge clka) rom_data <= ramWord(rom_addr);

   function automatic bit inWindow(input int h, input int v);
      return (h >= X_OFFSET) && (h < X_OFFSET + 512) && (v < V_ACTIVE);
   endfunction

   function automatic logic [15:0] imgAddr(input int h, input int v, input logic [7:0] sc);
      int x;
      int y;
      x = (((h - X_OFFSET) / 2) + int'(sc)) % 256;
      y = v / 2;
      return 16'(y * 256 + x);
   endfunction

   // Predict the pins after one clka edge from the pixel index counted since reset.
   task automatic applyStimulus(input logic rstIn, input logic [7:0] scrollIn);
      int tick;
      int m;
      int p;
      int ph;
      int pv;
      rsta     = rstIn;
      scroll_x = scrollIn;
      @(posedge clka);
      totalEdge++;
      if (rstIn) begin
         kEdge       = 0;
         mAddr       = 16'h0000;
         mAddrScroll = 8'h00;
         cur = '{addr: 16'h0000, rgb: 12'h000, hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, edgeNo: 0};
      end else begin
         kEdge++;
         cur.fs = 1'b0;
         if (kEdge % CLK_DIV == 0) begin
            tick = kEdge / CLK_DIV;
            m    = tick - 1;
`ifdef SCROLL_EN
            if (m > 0 && m % FRAME == 0) begin
               mAddrScroll = scroll_x;
            end
`endif
            if (inWindow(m % H_TOT, (m / H_TOT) % V_TOT)) begin
               mAddr = imgAddr(m % H_TOT, (m / H_TOT) % V_TOT, mAddrScroll);
            end
            cur.addr = mAddr;
            if (tick >= 2) begin
               p       = tick - 2;
               ph      = p % H_TOT;
               pv      = (p / H_TOT) % V_TOT;
               cur.de  = (ph < H_ACTIVE) && (pv < V_ACTIVE);
               cur.rgb = inWindow(ph, pv) ? ramWord(imgAddr(ph, pv, mAddrScroll))
                                          : (cur.de ? BG_COLOR : 12'h000);
               cur.hs  = !((ph >= H_ACTIVE + H_FP) && (ph < H_ACTIVE + H_FP + H_SYNC));
               cur.vs  = !((pv >= V_ACTIVE + V_FP) && (pv < V_ACTIVE + V_FP + V_SYNC));
            end
            cur.fs = (tick % FRAME == 0);
         end
      end
      cur.edgeNo = totalEdge;
      expQ.push_back(cur);
      #2;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         if (failCount >= MAX_FAIL) break;
         if ((kEdge % CLK_DIV == 2) && ((kEdge / CLK_DIV) % FRAME == FRAME / 2)) begin
            scrollVal = 8'($urandom);
         end
         applyStimulus(1'b0, scrollVal);
      end
   endtask

   task automatic compareField(input string name, input logic [15:0] got,
                               input logic [15:0] want, input int edgeNo);
      testsRun++;
      if (got !== want) begin
         failCount++;
         $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeNo, got, want);
      end
   endtask

   task automatic checkOutput(input pinState_t e);
      compareField("rom_addr", rom_addr, e.addr, e.edgeNo);
      compareField("rgb", 16'({vga_r, vga_g, vga_b}), 16'(e.rgb), e.edgeNo);
      compareField("vga_hs", 16'(vga_hs), 16'(e.hs), e.edgeNo);
      compareField("vga_vs", 16'(vga_vs), 16'(e.vs), e.edgeNo);
      compareField("vga_de", 16'(vga_de), 16'(e.de), e.edgeNo);
      compareField("frame_start", 16'(frame_start), 16'(e.fs), e.edgeNo);
   endtask

   // Monitor: one expected pin state per clka edge, checked half a period later.
   initial begin
      pinState_t e;
      forever begin
         @(negedge clka);
         if (expQ.size() > 1) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL scoreboard_depth: got %0d entries, expected at most 1", expQ.size());
         end
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      ramSalt   = 12'($urandom);
      scrollVal = 8'h00;
      rsta      = 1'b1;
      scroll_x  = 8'h00;
      #2;
      repeat (3) applyStimulus(1'b1, scrollVal);
      runCycles(CLK_DIV * (FRAME + $urandom_range(200, 1500)) + $urandom_range(0, CLK_DIV - 1));
      applyStimulus(1'b1, scrollVal);
      runCycles(CLK_DIV * (FRAME + 400));
      @(negedge clka);
      #1;
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
